riscv_soc: RTL and testbench
============================

Name: riscv_soc

Overview:
- Minimal RV32I system-on-chip: a single-cycle integer core plus an instruction ROM, with no external I/O besides clock and reset.
- The core fetches from the ROM and executes one instruction per clock.
- Benches observe architectural state through fixed hierarchical paths into the register file.
- Benches preload the ROM through a fixed hierarchical path to the ROM array.

Parameters:
- ROM_DEPTH, 4096, number of 32-bit words in instruction ROM.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = in reset).

Behaviour:
- Fixed hierarchy, required by benches:
  - instance rom_inst holds array rom_mem[0:ROM_DEPTH-1], 32-bit words, loadable by $readmemh (one hex word per line, word 0 at address 0).
  - instance riscv_inst contains instance regs_inst, which holds array regs[0:31], 32-bit.
- Reset (rst=0, asynchronous):
  - PC := RESET_PC.
  - All regs[1..31] := 0.
  - ROM contents untouched.
- Release: the first fetch is at RESET_PC on the first rising edge after rst goes high.
- Fetch:
  - ROM read is combinational.
  - instr = rom_mem[PC[31:2]]; PC bits [1:0] are ignored.
  - Out-of-range index returns 32'h0000_0013 (NOP).
- Execution: single cycle, so each rising edge retires exactly one instruction (writes rd, updates PC). No stalls, no pipeline hazards.
- Register file:
  - two combinational read ports, one synchronous write port.
  - x0 reads 0 always; writes to x0 are discarded.
- Supported instructions, full RV32I semantics, 32-bit wrap-around arithmetic:
  - LUI, AUIPC.
  - JAL, JALR: rd = PC+4; the JALR target has bit 0 cleared.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - OP-IMM: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
  - OP: ADD SUB SLL SLT SLTU XOR OR AND SRL SRA.
- Immediates are sign-extended per the I/S/B/U/J formats.
- Shift amount is the low 5 bits of the operand or of the immediate.
- Next PC:
  - PC+4 by default.
  - branch taken: PC + B-imm.
  - JAL: PC + J-imm.
  - JALR: (rs1 + I-imm) & ~1.
- Not implemented, treated as NOP (PC+4, no register write):
  - loads, stores, FENCE, ECALL, EBREAK, CSR instructions.
  - any unrecognised opcode.
- Misaligned jump or branch targets raise no exception.
- Test protocol, software-defined:
  - test programs write x26=1 on completion.
  - x27=1 means pass, x27=0 means fail.
  - x3 holds the current test number.
  - The SoC has no special handling for these registers.
- Reset asserted mid-run: state returns immediately to the reset values above; execution restarts at RESET_PC after release.

Test Plan:
- Reset: hold rst=0 for 30 ns with a 20 ns clock. All regs read 0 and PC=0. After release, the first instruction executes at address 0.
- ALU: preload ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; SRAI x5,x2,1. Required: x3=2, x4=0xFFFFFFF8, x5=0xFFFFFFFE.
- x0/LUI: LUI x0,0x12345; LUI x6,0x12345; ADDI x6,x6,0x678. Required: x0=0, x6=0x12345678.
- Control flow:
  - BNE skip: when taken, the skipped ADDI leaves its rd unchanged.
  - JAL x1,+8 at PC=0x10: x1=0x14, next PC=0x18.
  - JALR back to x1: PC=0x14.
- Compliance: load rv32ui-p-add hex (ROM_DEPTH 4096). Within 100 µs, x26 becomes 1. 200 ns later x27=1 ("pass add"); on failure the bench dumps x0..x31.
- Reset mid-run: drop rst for one cycle during a loop. PC returns to 0, regs clear, and the program re-runs to the same final register values.

Source files
------------

// File: rtl/riscv_soc.sv
// Minimal RV32I SoC: single-cycle integer core fetching from a combinational instruction ROM.
// Loads, stores, FENCE, SYSTEM and unknown opcodes retire as NOPs.

module SocRom #(
  parameter int ROM_DEPTH = 4096
) (
  input  logic [29:0] i_wordAddr,
  output logic [31:0] o_instr
);
  localparam int AW = $clog2(ROM_DEPTH);

  // Contents are preloaded externally through the hierarchy by the bench.
  logic [31:0] rom_mem [0:ROM_DEPTH-1];

  always_comb begin
    o_instr = 32'h0000_0013;
    if ({2'b00, i_wordAddr} < 32'(ROM_DEPTH))
      o_instr = rom_mem[i_wordAddr[AW-1:0]];
  end
endmodule

module RegFile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_raddrA,
  input  logic [4:0]  i_raddrB,
  output logic [31:0] o_rdataA,
  output logic [31:0] o_rdataB,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_we && i_waddr != 5'd0) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdataA = (i_raddrA == 5'd0) ? 32'd0 : regs[i_raddrA];
  assign o_rdataB = (i_raddrB == 5'd0) ? 32'd0 : regs[i_raddrB];
endmodule

module RiscvCore #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_instr,
  output logic [29:0] o_fetchAddr
);
  logic [31:0] r_pc;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_immI;
  logic [31:0] w_immB;
  logic [31:0] w_immU;
  logic [31:0] w_immJ;
  logic [31:0] w_rs1Data;
  logic [31:0] w_rs2Data;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_nextPc;
  logic [31:0] w_rdData;
  logic        w_we;
  logic        w_taken;

  function automatic logic [31:0] aluOp(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    case (f3)
      3'b000:  res = alt ? (a - b) : (a + b);
      3'b001:  res = a << b[4:0];
      3'b010:  res = {31'd0, $signed(a) < $signed(b)};
      3'b011:  res = {31'd0, a < b};
      3'b100:  res = a ^ b;
      3'b101:  res = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  res = a | b;
      default: res = a & b;
    endcase
    return res;
  endfunction

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_funct7 = i_instr[31:25];
  assign w_immI   = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_immB   = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_immU   = {i_instr[31:12], 12'd0};
  assign w_immJ   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_pcPlus4   = r_pc + 32'd4;
  assign o_fetchAddr = r_pc[31:2];

  RegFile regs_inst (
    .clk      (clk),
    .rst      (rst),
    .i_raddrA (w_rs1),
    .i_raddrB (w_rs2),
    .o_rdataA (w_rs1Data),
    .o_rdataB (w_rs2Data),
    .i_we     (w_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_rdData)
  );

  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_taken = (w_rs1Data == w_rs2Data);
      3'b001:  w_taken = (w_rs1Data != w_rs2Data);
      3'b100:  w_taken = ($signed(w_rs1Data) <  $signed(w_rs2Data));
      3'b101:  w_taken = ($signed(w_rs1Data) >= $signed(w_rs2Data));
      3'b110:  w_taken = (w_rs1Data <  w_rs2Data);
      3'b111:  w_taken = (w_rs1Data >= w_rs2Data);
      default: w_taken = 1'b0;
    endcase
  end

  // Decode/execute: anything not matched below retires as a NOP.
  always_comb begin
    w_we     = 1'b0;
    w_rdData = 32'd0;
    w_nextPc = w_pcPlus4;
    case (w_opcode)
      7'b0110111: begin
        w_we     = 1'b1;
        w_rdData = w_immU;
      end
      7'b0010111: begin
        w_we     = 1'b1;
        w_rdData = r_pc + w_immU;
      end
      7'b1101111: begin
        w_we     = 1'b1;
        w_rdData = w_pcPlus4;
        w_nextPc = r_pc + w_immJ;
      end
      7'b1100111: begin
        if (w_funct3 == 3'b000) begin
          w_we     = 1'b1;
          w_rdData = w_pcPlus4;
          w_nextPc = (w_rs1Data + w_immI) & ~32'd1;
        end
      end
      7'b1100011: begin
        if (w_taken) w_nextPc = r_pc + w_immB;
      end
      7'b0010011: begin
        w_we     = 1'b1;
        w_rdData = aluOp(w_funct3, (w_funct3 == 3'b101) && i_instr[30], w_rs1Data, w_immI);
      end
      7'b0110011: begin
        if (w_funct7 == 7'h00 ||
            (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
          w_we     = 1'b1;
          w_rdData = aluOp(w_funct3, w_funct7[5], w_rs1Data, w_rs2Data);
        end
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= RESET_PC;
    else      r_pc <= w_nextPc;
  end
endmodule

module riscv_soc #(
  parameter int          ROM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  logic [29:0] w_fetchAddr;
  logic [31:0] w_instr;

  SocRom #(.ROM_DEPTH(ROM_DEPTH)) rom_inst (
    .i_wordAddr (w_fetchAddr),
    .o_instr    (w_instr)
  );

  RiscvCore #(.RESET_PC(RESET_PC)) riscv_inst (
    .clk         (clk),
    .rst         (rst),
    .i_instr     (w_instr),
    .o_fetchAddr (w_fetchAddr)
  );
endmodule

// File: tb/tb_riscv_soc.sv
// Directed bench for riscv_soc: preloads small programs into the ROM and checks
// architectural state through the register-file and PC hierarchy.

module tb_riscv_soc;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] progBuf [$];

  riscv_soc #(.ROM_DEPTH(4096), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [31:0] readReg(input int idx);
    return dut.riscv_inst.regs_inst.regs[idx];
  endfunction

  function automatic logic [31:0] readPc();
    return dut.riscv_inst.r_pc;
  endfunction

  // Asserts reset 5 ns after a rising edge, loads progBuf (rest NOP), holds 30 ns.
  task automatic startProgram();
    @(posedge clk);
    #5;
    rst = 1'b0;
    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = 32'h0000_0013;
    for (int i = 0; i < progBuf.size(); i++) dut.rom_inst.rom_mem[i] = progBuf[i];
    #30;
    rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    progBuf = '{32'h00700093, 32'h00900113};
    startProgram();
    step(1);
    checks++;
    if (readReg(1) !== 32'd7) begin
      errors++;
      $display("[TB] FAIL reset_first_fetch x1: got %h expected %h", readReg(1), 32'd7);
    end
    checks++;
    if (readPc() !== 32'h4) begin
      errors++;
      $display("[TB] FAIL reset_first_pc: got %h expected %h", readPc(), 32'h4);
    end
    step(1);
    @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    checks++;
    if (readPc() !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_pc: got %h expected %h", readPc(), 32'h0);
    end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (readReg(r) !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_reg x%0d: got %h expected %h", r, readReg(r), 32'd0);
      end
    end
    #29;
    rst = 1'b1;
  endtask

  task automatic test_alu();
    progBuf = '{32'h00500093, 32'hFFD00113, 32'h002081B3, 32'h40110233, 32'h40115293};
    startProgram();
    step(5);
    checks++;
    if (readReg(2) !== 32'hFFFF_FFFD) begin
      errors++;
      $display("[TB] FAIL alu_addi_neg x2: got %h expected %h", readReg(2), 32'hFFFF_FFFD);
    end
    checks++;
    if (readReg(3) !== 32'd2) begin
      errors++;
      $display("[TB] FAIL alu_add x3: got %h expected %h", readReg(3), 32'd2);
    end
    checks++;
    if (readReg(4) !== 32'hFFFF_FFF8) begin
      errors++;
      $display("[TB] FAIL alu_sub x4: got %h expected %h", readReg(4), 32'hFFFF_FFF8);
    end
    checks++;
    if (readReg(5) !== 32'hFFFF_FFFE) begin
      errors++;
      $display("[TB] FAIL alu_srai x5: got %h expected %h", readReg(5), 32'hFFFF_FFFE);
    end
  endtask

  task automatic test_lui_x0();
    progBuf = '{32'h12345037, 32'h12345337, 32'h67830313};
    startProgram();
    step(3);
    checks++;
    if (readReg(0) !== 32'd0) begin
      errors++;
      $display("[TB] FAIL lui_x0: got %h expected %h", readReg(0), 32'd0);
    end
    checks++;
    if (readReg(6) !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL lui_addi x6: got %h expected %h", readReg(6), 32'h1234_5678);
    end
  endtask

  task automatic test_control_flow();
    // 0x00 ADDI x1,x0,5 / 0x04 BNE x1,x0,+8 / 0x08 ADDI x7,x0,99 / 0x0C BEQ x1,x0,+8
    // 0x10 JAL x1,+8 / 0x14 ADDI x9,x0,0x55 / 0x18 JALR x0,0(x1)
    progBuf = '{32'h00500093, 32'h00009463, 32'h06300393, 32'h00008463,
                32'h008000EF, 32'h05500493, 32'h00008067};
    startProgram();
    step(2);
    checks++;
    if (readPc() !== 32'h0C) begin
      errors++;
      $display("[TB] FAIL bne_taken_pc: got %h expected %h", readPc(), 32'h0C);
    end
    step(1);
    checks++;
    if (readPc() !== 32'h10) begin
      errors++;
      $display("[TB] FAIL beq_not_taken_pc: got %h expected %h", readPc(), 32'h10);
    end
    step(1);
    checks++;
    if (readReg(1) !== 32'h14) begin
      errors++;
      $display("[TB] FAIL jal_link x1: got %h expected %h", readReg(1), 32'h14);
    end
    checks++;
    if (readPc() !== 32'h18) begin
      errors++;
      $display("[TB] FAIL jal_target_pc: got %h expected %h", readPc(), 32'h18);
    end
    step(1);
    checks++;
    if (readPc() !== 32'h14) begin
      errors++;
      $display("[TB] FAIL jalr_target_pc: got %h expected %h", readPc(), 32'h14);
    end
    step(1);
    checks++;
    if (readReg(9) !== 32'h55) begin
      errors++;
      $display("[TB] FAIL after_jalr x9: got %h expected %h", readReg(9), 32'h55);
    end
    checks++;
    if (readReg(7) !== 32'd0) begin
      errors++;
      $display("[TB] FAIL branch_skip x7: got %h expected %h", readReg(7), 32'd0);
    end
  endtask

  task automatic test_out_of_range();
    // LUI x5,0x4 ; JALR x0,1(x5) -> target 0x4000 (bit 0 cleared), past the ROM end
    progBuf = '{32'h000042B7, 32'h00128067};
    startProgram();
    step(2);
    checks++;
    if (readPc() !== 32'h4000) begin
      errors++;
      $display("[TB] FAIL jalr_bit0_clear pc: got %h expected %h", readPc(), 32'h4000);
    end
    step(1);
    checks++;
    if (readPc() !== 32'h4004) begin
      errors++;
      $display("[TB] FAIL oob_nop pc: got %h expected %h", readPc(), 32'h4004);
    end
    checks++;
    if (readReg(5) !== 32'h4000) begin
      errors++;
      $display("[TB] FAIL oob_nop x5: got %h expected %h", readReg(5), 32'h4000);
    end
  endtask

  task automatic test_compliance();
    int cyc;
    progBuf = '{32'h00100193, 32'hFFF00513, 32'h01C55593, 32'h00F00613,
                32'h00C59863, 32'h00100D93, 32'h00100D13, 32'h0000006F,
                32'h00100D13, 32'h0000006F};
    startProgram();
    cyc = 0;
    while (readReg(26) !== 32'd1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (readReg(26) !== 32'd1) begin
      errors++;
      $display("[TB] FAIL compliance_done x26: got %h expected %h", readReg(26), 32'd1);
    end
    #200;
    checks++;
    if (readReg(27) !== 32'd1) begin
      errors++;
      $display("[TB] FAIL compliance_pass x27: got %h expected %h (test %0d)",
               readReg(27), 32'd1, readReg(3));
      for (int r = 0; r < 32; r++) $display("[TB] x%0d = %h", r, readReg(r));
    end else begin
      $display("[TB] pass add");
    end
  endtask

  task automatic test_reset_midrun();
    // 0x00 ADDI x1,x0,0 / 0x04 ADDI x2,x0,10 / 0x08 ADDI x1,x1,1 / 0x0C BNE x1,x2,-4
    // 0x10 ADDI x4,x0,0x77 / 0x14 JAL x0,0
    progBuf = '{32'h00000093, 32'h00A00113, 32'h00108093, 32'hFE209EE3,
                32'h07700213, 32'h0000006F};
    startProgram();
    step(10);
    checks++;
    if (readReg(1) !== 32'd4) begin
      errors++;
      $display("[TB] FAIL midrun_progress x1: got %h expected %h", readReg(1), 32'd4);
    end
    @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    checks++;
    if (readPc() !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midrun_reset_pc: got %h expected %h", readPc(), 32'h0);
    end
    checks++;
    if (readReg(1) !== 32'd0 || readReg(2) !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset_regs: got x1=%h x2=%h expected 0", readReg(1), readReg(2));
    end
    #19;
    rst = 1'b1;
    step(30);
    checks++;
    if (readReg(1) !== 32'd10) begin
      errors++;
      $display("[TB] FAIL midrun_rerun x1: got %h expected %h", readReg(1), 32'd10);
    end
    checks++;
    if (readReg(4) !== 32'h77) begin
      errors++;
      $display("[TB] FAIL midrun_rerun x4: got %h expected %h", readReg(4), 32'h77);
    end
    checks++;
    if (readPc() !== 32'h14) begin
      errors++;
      $display("[TB] FAIL midrun_rerun pc: got %h expected %h", readPc(), 32'h14);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    test_reset();
    test_alu();
    test_lui_x0();
    test_control_flow();
    test_out_of_range();
    test_compliance();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
